// File: rtl/mv_job_sequencer.sv
`timescale 1ns/1ps
// Sequences one motion-estimation job through the SAE engine: reset pulse, byte
// streaming into s_data, fixed compute wait, then capture into a valid/ready result register.
module mv_job_sequencer #(
    parameter int BLK_BYTES   = 16,
    parameter int WIN_BYTES   = 64,
    parameter int RST_CYCLES  = 2,
    parameter int COMP_CYCLES = 64
) (
    input  logic       wb_clk_i,
    input  logic       wb_rst_i,
    input  logic       start,
    input  logic       abort,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       eng_rst,
    output logic [7:0] eng_s_data,
    input  logic [9:0] eng_min_sae,
    input  logic [2:0] eng_mv_x,
    input  logic [2:0] eng_mv_y,
    output logic       res_valid,
    input  logic       res_ready,
    output logic [9:0] res_sae,
    output logic [2:0] res_mv_x,
    output logic [2:0] res_mv_y,
    output logic       busy,
    output logic       err_underrun,
    output logic [7:0] job_cnt
);

    localparam int TOTAL_BYTES = BLK_BYTES + WIN_BYTES;
    localparam int MAX_A       = (TOTAL_BYTES > COMP_CYCLES) ? TOTAL_BYTES : COMP_CYCLES;
    localparam int MAX_CNT     = (MAX_A > RST_CYCLES) ? MAX_A : RST_CYCLES;
    localparam int CNT_W       = $clog2(MAX_CNT + 1);

    localparam logic [CNT_W-1:0] RST_LAST  = CNT_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0] BYTE_LAST = CNT_W'(TOTAL_BYTES - 1);
    localparam logic [CNT_W-1:0] COMP_LAST = CNT_W'(COMP_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

    typedef enum logic [2:0] {
        IDLE,
        ERST,
        LOAD,
        COMP,
        WOUT
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic             comp_last;
    logic             capture;

    // A capture may reuse the result slot in the same cycle the consumer drains it.
    assign comp_last = (state == COMP) && (cnt == COMP_LAST);
    assign capture   = !abort && (!res_valid || res_ready) && (comp_last || state == WOUT);

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state        <= IDLE;
            cnt          <= '0;
            eng_rst      <= 1'b1;
            in_ready     <= 1'b0;
            eng_s_data   <= '0;
            res_valid    <= 1'b0;
            res_sae      <= '0;
            res_mv_x     <= '0;
            res_mv_y     <= '0;
            busy         <= 1'b0;
            err_underrun <= 1'b0;
            job_cnt      <= '0;
        end else begin
            if (res_valid && res_ready) begin
                res_valid <= 1'b0;
            end

            if (abort && state != IDLE) begin
                state      <= IDLE;
                cnt        <= '0;
                eng_rst    <= 1'b1;
                in_ready   <= 1'b0;
                eng_s_data <= '0;
                busy       <= 1'b0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start && !abort) begin
                            state        <= ERST;
                            cnt          <= '0;
                            busy         <= 1'b1;
                            err_underrun <= 1'b0;
                        end
                    end
                    ERST: begin
                        if (cnt == RST_LAST) begin
                            state    <= LOAD;
                            cnt      <= '0;
                            eng_rst  <= 1'b0;
                            in_ready <= 1'b1;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    LOAD: begin
                        // The engine cannot stall, so a missing byte kills the job.
                        if (!in_valid) begin
                            state        <= IDLE;
                            cnt          <= '0;
                            err_underrun <= 1'b1;
                            eng_s_data   <= '0;
                            eng_rst      <= 1'b1;
                            in_ready     <= 1'b0;
                            busy         <= 1'b0;
                        end else begin
                            eng_s_data <= in_data;
                            if (cnt == BYTE_LAST) begin
                                state    <= COMP;
                                cnt      <= '0;
                                in_ready <= 1'b0;
                            end else begin
                                cnt <= cnt + CNT_ONE;
                            end
                        end
                    end
                    COMP: begin
                        eng_s_data <= '0;
                        if (comp_last) begin
                            state <= WOUT;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CNT_ONE;
                        end
                    end
                    WOUT: ;
                    default: state <= IDLE;
                endcase

                if (capture) begin
                    res_valid <= 1'b1;
                    res_sae   <= eng_min_sae;
                    res_mv_x  <= eng_mv_x;
                    res_mv_y  <= eng_mv_y;
                    job_cnt   <= job_cnt + 8'd1;
                    state     <= IDLE;
                    eng_rst   <= 1'b1;
                    busy      <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/mv_job_sequencer.md
Name: mv_job_sequencer

Overview:
- Sequences one motion-estimation job through the SAE engine (top_level): holds the engine in reset between jobs and streams current-block plus search-window bytes into its serial s_data input.
- Waits a fixed compute interval, then captures min_sae and motion vector into a valid/ready result register.
- Sits between the host/IO byte source and the engine inside the user project wrapper.

Parameters:
- BLK_BYTES, 16, current-block bytes streamed first.
- WIN_BYTES, 64, search-window bytes streamed after the block.
- RST_CYCLES, 2, engine reset pulse length (cycles) before LOAD; min 1.
- COMP_CYCLES, 64, cycles from last streamed byte to result capture; min 1.

Ports:
- wb_clk_i  in  1  clock; all logic on rising edge.
- wb_rst_i  in  1  synchronous, active-high reset.
- start  in  1  job request pulse; sampled in IDLE only.
- abort  in  1  cancel current job; any state.
- in_data  in  8  pixel byte from source.
- in_valid  in  1  in_data valid.
- in_ready  out  1  byte accepted when in_valid&in_ready.
- eng_rst  out  1  engine reset, active-high.
- eng_s_data  out  8  registered byte to engine s_data.
- eng_min_sae  in  10  engine min SAE.
- eng_mv_x  in  3  engine motion vector x.
- eng_mv_y  in  3  engine motion vector y.
- res_valid  out  1  result register holds unconsumed result.
- res_ready  in  1  consumer accepts result.
- res_sae  out  10  captured min SAE.
- res_mv_x  out  3  captured mv x.
- res_mv_y  out  3  captured mv y.
- busy  out  1  state != IDLE.
- err_underrun  out  1  sticky: last job aborted by source underrun.
- job_cnt  out  8  completed-job count, wraps 255->0.

Behaviour:
- Reset (wb_rst_i=1): state IDLE; eng_rst=1; in_ready=0; eng_s_data=0; res_valid=0; res_sae/res_mv_x/res_mv_y=0; busy=0; err_underrun=0; job_cnt=0; counters 0.
- States: IDLE, ERST, LOAD, COMP, WOUT.
- IDLE: eng_rst=1, in_ready=0. start=1 and abort=0 -> ERST; clear err_underrun.
- ERST: eng_rst=1 for exactly RST_CYCLES cycles -> LOAD.
- LOAD: eng_rst=0, in_ready=1. Engine consumes one byte per cycle, no stall.
  - Each LOAD cycle with in_valid=1: eng_s_data <= in_data (visible next cycle); byte counter++.
  - Byte BLK_BYTES+WIN_BYTES-1 accepted -> COMP.
  - in_valid=0 in any LOAD cycle (underrun) -> IDLE; err_underrun=1; eng_s_data<=0; no result; job_cnt unchanged.
- COMP: eng_rst=0, in_ready=0, eng_s_data=0. Counts COMP_CYCLES cycles.
  - In the last COMP cycle: if res_valid=0, or res_valid&res_ready that cycle, capture eng_* into res_*, set res_valid=1, job_cnt++, -> IDLE.
  - Otherwise -> WOUT.
- WOUT: eng_rst=0, engine outputs held. Capture in the first cycle where res_valid=0 or res_ready=1, then -> IDLE as above.
- Result handshake: res_valid falls the cycle after res_valid&res_ready unless a capture happens the same cycle; a capture then wins (res_valid stays 1, new data). res_* stable while res_valid=1 and not accepted.
- abort=1 in any non-IDLE state: next state IDLE; in_ready=0 next cycle; no capture; err_underrun and res_* untouched. abort has priority over start, underrun and capture in the same cycle.
- start outside IDLE is ignored; it is not queued.
- Latency, start pulse to res_valid with no stalls: 1 + RST_CYCLES + (BLK_BYTES+WIN_BYTES) + COMP_CYCLES cycles. Default: 1+2+80+64 = 147.
- wb_rst_i mid-job returns everything to reset values next edge.

Test Plan:
- Nominal: reset, start, 80 contiguous bytes 0..79, engine model returns sae=0x155, mv=(3,5) -> eng_rst high 3 cycles after start, eng_s_data shows 0..79 one per cycle lagging in_data by 1, res_valid rises 147 cycles after start with res_sae=0x155, res_mv_x=3, res_mv_y=5, job_cnt=1.
- Underrun: drop in_valid at byte 40 -> next cycle state IDLE, err_underrun=1, eng_rst=1, res_valid stays 0, job_cnt=0; a new start clears err_underrun.
- Back-pressure: res_ready=0, run two jobs -> second job sits in WOUT, busy=1; raise res_ready -> first result consumed, second captured same cycle, res_valid stays 1, job_cnt=2.
- Abort: assert abort mid-LOAD and mid-COMP, and together with start in IDLE -> IDLE next cycle, no capture, err_underrun=0, job_cnt unchanged.
- Wrap/reset: complete 256 jobs -> job_cnt=0; assert wb_rst_i during COMP -> all outputs at reset values next cycle, including res_valid=0.
